imem_boot_loader: RTL and testbench
===================================

Name: imem_boot_loader

Overview:
Upstream stage of the single-cycle CPU. It receives a program as a byte stream over a valid/ready handshake and assembles the bytes into 32-bit little-endian words. It writes the words sequentially into the instruction memory write port, holding the CPU in reset throughout the load. After the last word is written it releases the CPU reset and reports done, along with a running 32-bit checksum of the written words.

Parameters:
numInstructions, 16, number of 32-bit words to load; legal range 0..2^30-1.
baseAddr, 32'h0000_0000, byte address of the first word written (word-aligned).

Ports:
i_clock  input  1  system clock; all state updates on rising edge.
i_reset  input  1  synchronous, active-high reset.
i_byte  input  8  incoming program byte.
i_valid  input  1  i_byte is valid this cycle.
o_ready  output  1  loader can accept a byte this cycle.
o_imem_we  output  1  one-cycle write strobe to instruction memory.
o_imem_addr  output  32  byte address of the word being written.
o_imem_data  output  32  assembled instruction word.
o_cpu_reset  output  1  reset to the CPU/PC; high until the load completes.
o_done  output  1  load complete.
o_checksum  output  32  modulo-2^32 sum of all words written since reset.

Behaviour:
- States: LOAD, WRITE, DONE.
- Reset (i_reset=1 at a rising edge):
  - state goes to LOAD, or to DONE if numInstructions==0.
  - byte_cnt=0, word_cnt=0, assembled word=0, o_checksum=0.
  - o_imem_we=0, o_imem_addr=baseAddr, o_imem_data=0.
  - o_cpu_reset=1, o_done=0.
- Accept: a byte is accepted on an edge where i_valid & o_ready. o_ready=1 only in LOAD. o_ready has no combinational dependence on i_valid.
- Assembly: the k-th accepted byte of a word (k=0..3) lands in bits [8k+7:8k]. byte_cnt wraps 3->0.
- LOAD:
  - On acceptance of byte 3, the word is complete; next state is WRITE.
  - Otherwise remain in LOAD. Cycles with i_valid=0 do not change state.
- WRITE (exactly one cycle):
  - o_imem_we=1, o_imem_addr=baseAddr+4*word_cnt, o_imem_data=completed word, o_ready=0.
  - At the end of the cycle: o_checksum += word; word_cnt += 1.
  - Next state is DONE if word_cnt was numInstructions-1, else LOAD.
- DONE (terminal until reset):
  - o_ready=0, o_imem_we=0, o_cpu_reset=0, o_done=1.
  - Incoming bytes are ignored; o_checksum holds.
- o_imem_addr/o_imem_data are registered and hold their last values outside WRITE. Only the o_imem_we=1 cycle is meaningful.
- Latency:
  - WRITE asserts in the cycle immediately after the edge that accepts byte 3.
  - o_cpu_reset falls in the cycle after the final WRITE cycle.
  - Minimum load time is 5*numInstructions cycles from reset release.
- Reset mid-operation (any state, including WRITE): the partial word is discarded and loading restarts at baseAddr. No write strobe occurs in the reset cycle or the cycle after it.
- Width: the address computation wraps modulo 2^32. word_cnt is 32 bits wide.

Test Plan:
- numInstructions=2, baseAddr=0: send bytes 13,00,50,00 then 93,00,10,00 with i_valid held high -> we pulses with addr 0/data 0x00500013, then addr 4/data 0x00100093. o_cpu_reset falls and o_done rises in cycle 11 after reset release. o_checksum=0x006000A6.
- Throttled stream: toggle i_valid 1,0,1,0 on the same 8 bytes -> identical writes and checksum. Each byte accepted exactly once. o_ready=0 during each WRITE cycle while i_valid=1.
- numInstructions=0 -> after reset: o_done=1, o_cpu_reset=0, o_ready=0, no we pulse, o_checksum=0.
- Reset asserted after 2 bytes of word 1 (numInstructions=2) -> after release, the next 4 bytes AA,BB,CC,DD write 0xDDCCBBAA to addr 0. No write of the stale partial word occurs.
- baseAddr=0x100, numInstructions=3, words 1,2,3 -> addrs 0x100/0x104/0x108, checksum 6. Extra bytes sent in DONE are not accepted and cause no we.
- Reset asserted in the WRITE cycle of word 0 -> the write is ignored by the bench model. Checksum stays 0, and the state is LOAD with word_cnt=0 after release.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes them
// sequentially into instruction memory and holds the CPU in reset until the load completes.
module imem_boot_loader #(
    parameter int unsigned numInstructions = 16,
    parameter logic [31:0] baseAddr        = 32'h0000_0000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [7:0]  i_byte,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_imem_we,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_imem_data,
    output logic        o_cpu_reset,
    output logic        o_done,
    output logic [31:0] o_checksum
);

    typedef enum logic [1:0] {
        StLoad,
        StWrite,
        StDone
    } state_e;

    // LastWord is never reached when numInstructions is zero, since reset goes straight to StDone.
    localparam logic [31:0] LastWord   = 32'(numInstructions) - 32'd1;
    localparam state_e      ResetState = (numInstructions == 0) ? StDone : StLoad;

    state_e      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] word_cnt_q, word_cnt_d;
    logic [31:0] word_q, word_d;
    logic [31:0] checksum_q, checksum_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] word_full;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= ResetState;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 32'd0;
            word_q     <= 32'd0;
            checksum_q <= 32'd0;
            addr_q     <= baseAddr;
            data_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_q     <= word_d;
            checksum_q <= checksum_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        word_d     = word_q;
        checksum_d = checksum_q;
        addr_d     = addr_q;
        data_d     = data_q;
        word_full  = word_q | ({24'd0, i_byte} << {byte_cnt_q, 3'b000});

        unique case (state_q)
            StLoad: begin
                if (i_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    word_d     = word_full;
                    if (byte_cnt_q == 2'd3) begin
                        // Capture the write beat now so address/data are registered in StWrite.
                        word_d  = 32'd0;
                        data_d  = word_full;
                        addr_d  = baseAddr + {word_cnt_q[29:0], 2'b00};
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                checksum_d = checksum_q + data_q;
                word_cnt_d = word_cnt_q + 32'd1;
                state_d    = (word_cnt_q == LastWord) ? StDone : StLoad;
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StLoad;
            end
        endcase
    end

    // The strobe is masked during reset so an interrupted write never reaches memory.
    assign o_ready     = (state_q == StLoad);
    assign o_imem_we   = (state_q == StWrite) && !i_reset;
    assign o_imem_addr = addr_q;
    assign o_imem_data = data_q;
    assign o_cpu_reset = (state_q != StDone);
    assign o_done      = (state_q == StDone);
    assign o_checksum  = checksum_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench: three loader configurations share one randomized byte stream and are
// checked every cycle against a transaction-level model of the load.
module tb_imem_boot_loader;

    logic        clk;
    logic        i_reset;
    logic [7:0]  i_byte;
    logic        i_valid;
    logic        rdy [3];
    logic        we  [3];
    logic        cr  [3];
    logic        dn  [3];
    logic [31:0] addr[3];
    logic [31:0] data[3];
    logic [31:0] cs  [3];

    int unsigned mn[3] = '{2, 0, 3};
    logic [31:0] mb[3] = '{32'h0, 32'h0, 32'h100};

    imem_boot_loader #(.numInstructions(2), .baseAddr(32'h0)) u0 (
        .i_clock(clk), .i_reset(i_reset), .i_byte(i_byte), .i_valid(i_valid),
        .o_ready(rdy[0]), .o_imem_we(we[0]), .o_imem_addr(addr[0]), .o_imem_data(data[0]),
        .o_cpu_reset(cr[0]), .o_done(dn[0]), .o_checksum(cs[0]));
    imem_boot_loader #(.numInstructions(0), .baseAddr(32'h0)) u1 (
        .i_clock(clk), .i_reset(i_reset), .i_byte(i_byte), .i_valid(i_valid),
        .o_ready(rdy[1]), .o_imem_we(we[1]), .o_imem_addr(addr[1]), .o_imem_data(data[1]),
        .o_cpu_reset(cr[1]), .o_done(dn[1]), .o_checksum(cs[1]));
    imem_boot_loader #(.numInstructions(3), .baseAddr(32'h100)) u2 (
        .i_clock(clk), .i_reset(i_reset), .i_byte(i_byte), .i_valid(i_valid),
        .o_ready(rdy[2]), .o_imem_we(we[2]), .o_imem_addr(addr[2]), .o_imem_data(data[2]),
        .o_cpu_reset(cr[2]), .o_done(dn[2]), .o_checksum(cs[2]));

    int n_cmp = 0;
    int n_bad = 0;

    // Model: bytes gathered so far, words completed, and a pending write beat.
    bit          m_done[3];
    bit          m_pend[3];
    int          m_nb[3];
    logic [31:0] m_word[3];
    logic [31:0] m_count[3];
    logic [31:0] m_csum[3];
    logic [31:0] m_addr[3];
    logic [31:0] m_data[3];
    bit          started = 0;
    logic [63:0] wlog0[$];
    logic [63:0] wlog2[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    // At each negedge the inputs are still those sampled at the preceding posedge.
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (i_reset) begin
                    m_done[k]  = (mn[k] == 0);
                    m_pend[k]  = 0;
                    m_nb[k]    = 0;
                    m_word[k]  = 32'd0;
                    m_count[k] = 32'd0;
                    m_csum[k]  = 32'd0;
                    m_addr[k]  = mb[k];
                    m_data[k]  = 32'd0;
                end else if (started && m_pend[k]) begin
                    m_csum[k]  = m_csum[k] + m_data[k];
                    m_count[k] = m_count[k] + 32'd1;
                    m_pend[k]  = 0;
                    m_done[k]  = (m_count[k] == mn[k]);
                end else if (started && !m_done[k] && i_valid) begin
                    m_word[k] = m_word[k] | (32'(i_byte) << (8 * m_nb[k]));
                    m_nb[k]++;
                    if (m_nb[k] == 4) begin
                        m_pend[k] = 1;
                        m_data[k] = m_word[k];
                        m_addr[k] = mb[k] + 32'd4 * m_count[k];
                        m_nb[k]   = 0;
                        m_word[k] = 32'd0;
                    end
                end
            end
            if (i_reset) begin
                started = 1;
                wlog0.delete();
                wlog2.delete();
            end
            if (started) begin
                for (int k = 0; k < 3; k++) begin
                    chk("ready", rdy[k], !m_done[k] && !m_pend[k]);
                    chk("we", we[k], m_pend[k] && !i_reset);
                    chk("cpu_reset", cr[k], !m_done[k]);
                    chk("done", dn[k], m_done[k]);
                    chk("checksum", cs[k], m_csum[k]);
                    if (m_pend[k] && !i_reset) begin
                        chk("addr", addr[k], m_addr[k]);
                        chk("data", data[k], m_data[k]);
                    end
                end
                if (we[0]) wlog0.push_back({addr[0], data[0]});
                if (we[2]) wlog2.push_back({addr[2], data[2]});
            end
        end
    end

    task automatic do_reset(input int n);
        i_reset = 1'b1;
        i_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
        i_reset = 1'b0;
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Present a byte until instance k accepts it; optionally drop valid for one cycle after.
    task automatic send(input int k, input logic [7:0] b, input bit throttle);
        bit acc;
        acc     = 0;
        i_byte  = b;
        i_valid = 1'b1;
        for (int t = 0; t < 20 && !acc; t++) begin
            acc = rdy[k];
            @(negedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 64'(acc), 64'd1);
        if (throttle) idle(1);
    endtask

    logic [7:0] prog[8] = '{8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    task automatic check_prog();
        chk("prog_wcount", 64'(wlog0.size()), 64'd2);
        if (wlog0.size() == 2) begin
            chk("prog_w0", wlog0[0], {32'h0, 32'h0050_0013});
            chk("prog_w1", wlog0[1], {32'h4, 32'h0010_0093});
        end
        chk("prog_csum", cs[0], 32'h0060_00A6);
        chk("prog_model_csum", m_csum[0], 32'h0060_00A6);
        chk("prog_done", dn[0], 1'b1);
        chk("prog_cpu_reset", cr[0], 1'b0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_byte  = 8'h00;
        do_reset(2);
        chk("rst_ready", rdy[0], 1'b1);
        chk("rst_cpu_reset", cr[0], 1'b1);
        chk("rst_addr", addr[0], 32'h0);
        chk("rst_addr2", addr[2], 32'h100);
        chk("n0_done", dn[1], 1'b1);
        chk("n0_cpu_reset", cr[1], 1'b0);
        chk("n0_ready", rdy[1], 1'b0);

        // Continuous stream
        for (int i = 0; i < 8; i++) send(0, prog[i], 1'b0);
        idle(3);
        check_prog();

        // Throttled stream
        do_reset(1);
        for (int i = 0; i < 8; i++) send(0, prog[i], 1'b1);
        idle(3);
        check_prog();

        // Reset after two bytes discards the partial word
        do_reset(1);
        send(0, 8'hAA, 1'b0);
        send(0, 8'hBB, 1'b0);
        do_reset(1);
        send(0, 8'hAA, 1'b0);
        send(0, 8'hBB, 1'b0);
        send(0, 8'hCC, 1'b0);
        send(0, 8'hDD, 1'b0);
        idle(2);
        chk("partial_wcount", 64'(wlog0.size()), 64'd1);
        if (wlog0.size() == 1) chk("partial_w0", wlog0[0], {32'h0, 32'hDDCC_BBAA});

        // Three words at base 0x100, then extra bytes while done
        do_reset(1);
        for (int w = 1; w <= 3; w++) begin
            send(2, 8'(w), 1'b0);
            for (int j = 0; j < 3; j++) send(2, 8'h00, 1'b0);
        end
        idle(2);
        i_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_byte = 8'($urandom);
            @(negedge clk);
            #1;
        end
        idle(1);
        chk("base_wcount", 64'(wlog2.size()), 64'd3);
        if (wlog2.size() == 3) begin
            chk("base_w0", wlog2[0], {32'h100, 32'h1});
            chk("base_w1", wlog2[1], {32'h104, 32'h2});
            chk("base_w2", wlog2[2], {32'h108, 32'h3});
        end
        chk("base_csum", cs[2], 32'd6);
        chk("base_done", dn[2], 1'b1);

        // Reset landing in the write cycle of word 0
        do_reset(1);
        for (int i = 0; i < 4; i++) send(0, prog[i], 1'b0);
        do_reset(1);
        chk("wrst_csum", cs[0], 32'd0);
        chk("wrst_wcount", 64'(wlog0.size()), 64'd0);
        chk("wrst_ready", rdy[0], 1'b1);
        for (int i = 4; i < 8; i++) send(0, prog[i], 1'b0);
        idle(2);
        chk("wrst_wcount2", 64'(wlog0.size()), 64'd1);
        if (wlog0.size() == 1) chk("wrst_w0", wlog0[0], {32'h0, 32'h0010_0093});

        // Randomized traffic with occasional resets
        do_reset(1);
        for (int c = 0; c < 400; c++) begin
            i_reset = ($urandom_range(0, 59) == 0);
            i_valid = 1'($urandom);
            i_byte  = 8'($urandom);
            @(negedge clk);
            #1;
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
